// File: rtl/hazard_tag_pipe_if.sv
// hazard_tag_pipe_if: ID-side inputs and EX/MEM/WB tag outputs of the hazard tag pipe
interface hazard_tag_pipe_if #(parameter int REG_W = 5, parameter int CNT_W = 16);
  logic             stall_in;
  logic             flush_ex;
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_usesRt;
  logic [REG_W-1:0] id_rd;
  logic             id_regWr;
  logic             id_memRd;
  logic             id_memWr;
  logic             id_stall;
  logic [REG_W-1:0] ex_rs;
  logic [REG_W-1:0] ex_rt;
  logic [REG_W-1:0] ex_rd;
  logic             ex_regWr;
  logic             ex_memRd;
  logic             ex_memWr;
  logic [REG_W-1:0] mem_rd;
  logic             mem_regWr;
  logic             mem_memWr;
  logic [REG_W-1:0] wb_rd;
  logic             wb_regWr;
  logic [CNT_W-1:0] lu_cnt;
  logic [CNT_W-1:0] fl_cnt;
  modport master (
    output stall_in, flush_ex, id_valid, id_rs, id_rt, id_usesRt, id_rd, id_regWr, id_memRd, id_memWr,
    input  id_stall, ex_rs, ex_rt, ex_rd, ex_regWr, ex_memRd, ex_memWr,
           mem_rd, mem_regWr, mem_memWr, wb_rd, wb_regWr, lu_cnt, fl_cnt
  );
  modport slave (
    input  stall_in, flush_ex, id_valid, id_rs, id_rt, id_usesRt, id_rd, id_regWr, id_memRd, id_memWr,
    output id_stall, ex_rs, ex_rt, ex_rd, ex_regWr, ex_memRd, ex_memWr,
           mem_rd, mem_regWr, mem_memWr, wb_rd, wb_regWr, lu_cnt, fl_cnt
  );
endinterface

// File: rtl/hazard_tag_pipe.sv
// hazard_tag_pipe: EX/MEM/WB register tags with load-use stall, branch flush, memory freeze and event counters
module hazard_tag_pipe #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input logic              CLK,
  input logic              RST,
  hazard_tag_pipe_if.slave bus
);
  logic             ex_v, ex_wr, ex_ld, ex_st, mem_v, mem_wr, mem_st, wb_v, wb_wr;
  logic [REG_W-1:0] ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic [CNT_W-1:0] lu_cnt, fl_cnt;
  logic             load_use, take;
  assign load_use = bus.id_valid & ex_v & ex_ld & (ex_rd != '0) &
                    ((ex_rd == bus.id_rs) | (bus.id_usesRt & (ex_rd == bus.id_rt)));
  assign take = bus.id_valid & ~bus.flush_ex & ~load_use;
  assign bus.id_stall  = bus.stall_in | (load_use & ~bus.flush_ex);
  assign bus.ex_rs     = ex_rs;
  assign bus.ex_rt     = ex_rt;
  assign bus.ex_rd     = ex_rd;
  assign bus.ex_regWr  = ex_wr & ex_v;
  assign bus.ex_memRd  = ex_ld & ex_v;
  assign bus.ex_memWr  = ex_st & ex_v;
  assign bus.mem_rd    = mem_rd;
  assign bus.mem_regWr = mem_wr & mem_v;
  assign bus.mem_memWr = mem_st & mem_v;
  assign bus.wb_rd     = wb_rd;
  assign bus.wb_regWr  = wb_wr & wb_v;
  assign bus.lu_cnt    = lu_cnt;
  assign bus.fl_cnt    = fl_cnt;
  // stage advance: bubbles and invalid slots carry zero tags so forwarding compares never hit stale data
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      {ex_v, ex_wr, ex_ld, ex_st, mem_v, mem_wr, mem_st, wb_v, wb_wr} <= '0;
      {ex_rs, ex_rt, ex_rd, mem_rd, wb_rd} <= '0;
      lu_cnt <= '0;
      fl_cnt <= '0;
    end else if (!bus.stall_in) begin
      ex_v   <= take;
      ex_rs  <= take ? bus.id_rs : '0;
      ex_rt  <= take ? bus.id_rt : '0;
      ex_rd  <= take ? bus.id_rd : '0;
      ex_wr  <= take & bus.id_regWr & (bus.id_rd != '0);
      ex_ld  <= take & bus.id_memRd;
      ex_st  <= take & bus.id_memWr;
      mem_v  <= ex_v;
      mem_rd <= ex_rd;
      mem_wr <= ex_wr;
      mem_st <= ex_st;
      wb_v   <= mem_v;
      wb_rd  <= mem_rd;
      wb_wr  <= mem_wr;
      if (bus.flush_ex) fl_cnt <= fl_cnt + CNT_W'(fl_cnt != '1);
      else if (load_use) lu_cnt <= lu_cnt + CNT_W'(lu_cnt != '1);
    end
  end
endmodule

// File: tb/tb_hazard_tag_pipe.sv
// tb_hazard_tag_pipe: directed stimulus with a queued scoreboard checked by a negedge monitor
module tb_hazard_tag_pipe;
  logic CLK = 0;
  logic RST;
  int   n_cmp = 0;
  int   n_bad = 0;
  hazard_tag_pipe_if #(.REG_W(5), .CNT_W(2)) bus ();
  hazard_tag_pipe #(.REG_W(5), .CNT_W(2)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #5 CLK = ~CLK;
  typedef struct {
    string       n;
    logic [35:0] v;
  } exp_t;
  exp_t q[$];
  function automatic logic [35:0] e(input logic st, input int ers, ert, erd, input logic [2:0] ef,
                                    input int mrd, input logic [1:0] mf, input int wrd,
                                    input logic ww, input int lu, fl);
    return {st, 5'(ers), 5'(ert), 5'(erd), ef, 5'(mrd), mf, 5'(wrd), ww, 2'(lu), 2'(fl)};
  endfunction
  // monitor: every negedge with a pending expectation compares the full observable state
  always @(negedge CLK) begin
    if (q.size() != 0) begin
      exp_t x;
      logic [35:0] a;
      x = q.pop_front();
      a = {bus.id_stall, bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.ex_regWr, bus.ex_memRd, bus.ex_memWr,
           bus.mem_rd, bus.mem_regWr, bus.mem_memWr, bus.wb_rd, bus.wb_regWr, bus.lu_cnt, bus.fl_cnt};
      n_cmp++;
      if (a !== x.v) begin
        n_bad++;
        $display("FAIL %s: got %h required %h", x.n, a, x.v);
      end
    end
  end
  task automatic drv(input logic si, fe, v, input int rs, rt, input logic ur, input int rd,
                     input logic rw, mr, mw);
    bus.stall_in  = si;
    bus.flush_ex  = fe;
    bus.id_valid  = v;
    bus.id_rs     = 5'(rs);
    bus.id_rt     = 5'(rt);
    bus.id_usesRt = ur;
    bus.id_rd     = 5'(rd);
    bus.id_regWr  = rw;
    bus.id_memRd  = mr;
    bus.id_memWr  = mw;
  endtask
  task automatic nop();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic step(input string n, input logic chk, input logic [35:0] v);
    if (chk) q.push_back('{n, v});
    @(posedge CLK);
    #1;
  endtask
  initial begin
    RST = 1;
    nop();
    repeat (2) @(posedge CLK);
    #1 RST = 0;
    nop();                                  step("T2 c0", 1, e(0, 0,0,0, 3'b000, 0, 2'b00, 0, 0, 0, 0));
    drv(0, 0, 1, 1, 2, 1, 3, 1, 0, 0);
    step("T2 idle", 1, e(0, 0,0,0, 3'b000, 0, 2'b00, 0, 0, 0, 0));
    nop();                                  step("T2 ex",  1, e(0, 1,2,3, 3'b100, 0, 2'b00, 0, 0, 0, 0));
    nop();                                  step("T2 mem", 1, e(0, 0,0,0, 3'b000, 3, 2'b10, 0, 0, 0, 0));
    nop();                                  step("T2 wb",  1, e(0, 0,0,0, 3'b000, 0, 2'b00, 3, 1, 0, 0));
    nop();                                  step("T2 end", 1, e(0, 0,0,0, 3'b000, 0, 2'b00, 0, 0, 0, 0));
    drv(0, 0, 1, 1, 0, 0, 5, 1, 1, 0);      step("T3 lw",  1, e(0, 0,0,0, 3'b000, 0, 2'b00, 0, 0, 0, 0));
    drv(0, 0, 1, 5, 2, 1, 6, 1, 0, 0);      step("T3 stall", 1, e(1, 1,0,5, 3'b110, 0, 2'b00, 0, 0, 0, 0));
    drv(0, 0, 1, 5, 2, 1, 6, 1, 0, 0);      step("T3 bubble", 1, e(0, 0,0,0, 3'b000, 5, 2'b10, 0, 0, 1, 0));
    nop();                                  step("T3 use", 1, e(0, 5,2,6, 3'b100, 0, 2'b00, 5, 1, 1, 0));
    nop();                                  step("T3 mem", 1, e(0, 0,0,0, 3'b000, 6, 2'b10, 0, 0, 1, 0));
    nop();                                  step("T3 wb",  1, e(0, 0,0,0, 3'b000, 0, 2'b00, 6, 1, 1, 0));
    drv(0, 0, 1, 1, 0, 0, 0, 1, 1, 0);      step("T4 lw0", 1, e(0, 0,0,0, 3'b000, 0, 2'b00, 0, 0, 1, 0));
    drv(0, 0, 1, 0, 0, 1, 7, 1, 0, 0);      step("T4 r0",  1, e(0, 1,0,0, 3'b010, 0, 2'b00, 0, 0, 1, 0));
    drv(0, 0, 1, 2, 0, 0, 5, 1, 1, 0);      step("T4 lw5", 1, e(0, 0,0,7, 3'b100, 0, 2'b00, 0, 0, 1, 0));
    drv(0, 0, 1, 3, 5, 0, 8, 1, 0, 0);      step("T4 nort", 1, e(0, 2,0,5, 3'b110, 7, 2'b10, 0, 0, 1, 0));
    nop();                                  step("T4 full", 1, e(0, 3,5,8, 3'b100, 5, 2'b10, 7, 1, 1, 0));
    nop();
    RST = 1;
    step("T1 reset", 1, e(0, 0,0,0, 3'b000, 0, 2'b00, 0, 0, 0, 0));
    RST = 0;
    drv(0, 0, 1, 1, 0, 0, 5, 1, 1, 0);      step("T5 lw",  1, e(0, 0,0,0, 3'b000, 0, 2'b00, 0, 0, 0, 0));
    drv(0, 1, 1, 5, 0, 0, 6, 1, 0, 0);      step("T5 flush", 1, e(0, 1,0,5, 3'b110, 0, 2'b00, 0, 0, 0, 0));
    nop();                                  step("T5 bubble", 1, e(0, 0,0,0, 3'b000, 5, 2'b10, 0, 0, 0, 1));
    nop();                                  step("T5 wb",  1, e(0, 0,0,0, 3'b000, 0, 2'b00, 5, 1, 0, 1));
    drv(0, 0, 1, 4, 6, 1, 0, 0, 0, 1);      step("T6 sw",  1, e(0, 0,0,0, 3'b000, 0, 2'b00, 0, 0, 0, 1));
    drv(0, 0, 1, 4, 0, 0, 9, 1, 1, 0);      step("T6 lw9", 1, e(0, 4,6,0, 3'b001, 0, 2'b00, 0, 0, 0, 1));
    for (int i = 0; i < 3; i++) begin
      drv(1, 0, 1, 9, 0, 0, 10, 1, 0, 0);   step("T6 freeze", 1, e(1, 4,0,9, 3'b110, 0, 2'b01, 0, 0, 0, 1));
    end
    drv(0, 0, 1, 9, 0, 0, 10, 1, 0, 0);     step("T6 thaw", 1, e(1, 4,0,9, 3'b110, 0, 2'b01, 0, 0, 0, 1));
    drv(0, 0, 1, 9, 0, 0, 10, 1, 0, 0);     step("T6 bubble", 1, e(0, 0,0,0, 3'b000, 9, 2'b10, 0, 0, 1, 1));
    repeat (3) begin
      nop();
      step("drain", 0, '0);
    end
    for (int i = 0; i < 5; i++) begin
      drv(0, 0, 1, 1, 0, 0, 5, 1, 1, 0);    step("sat lw", 0, '0);
      drv(0, 0, 1, 5, 0, 0, 6, 1, 0, 0);
      step("T6 sat stall", 1, e(1, 1,0,5, 3'b110, 0, 2'b00, 0, 0, (i + 1 > 3) ? 3 : i + 1, 1));
      nop();                                step("sat nop", 0, '0);
    end
    nop();                                  step("T6 sat", 1, e(0, 0,0,0, 3'b000, 0, 2'b00, 5, 1, 3, 1));
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge CLK);
    #1;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
